tk1_ctr_stream: RTL and testbench
=================================

Name: tk1_ctr_stream

Overview:
- Upstream producer of the TK1 tweakey word stream for the Romulus-N 32-bit datapath.
- Holds the 56-bit Romulus block-counter LFSR and the 8-bit domain separator.
- On request, serialises the 128-bit TK1 (counter || domain || 0^64) into four 32-bit beats over a valid/ready handshake, for loading into the tweakey state registers.

Parameters:
- CTR_INIT, 56'h00000000000001, counter value after reset or `ctr_init`.
- DOM_RST, 8'h00, domain register value after reset.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; synchronous, active-low (0 = reset).
- ctr_init  in  1  reload counter with CTR_INIT.
- ctr_inc  in  1  advance counter one LFSR step.
- dom_ld  in  1  load domain register from `dom_i`.
- dom_i  in  8  domain separator value.
- start  in  1  begin a 4-beat TK1 stream.
- busy  out  1  high while a stream is in progress.
- tk_o  out  32  current TK1 beat.
- tk_valid  out  1  `tk_o` is valid.
- tk_ready  in  1  downstream accepts the beat.
- ctr_o  out  56  current counter value, for debug and tag logic.

Behaviour:
- Reset (rst=0 at an edge):
  - ctr=CTR_INIT, dom=DOM_RST.
  - FSM=IDLE, beat=0.
  - tk_valid=0, busy=0, tk_o=0.
  - Reset mid-stream aborts the stream; no further beats are emitted.
- LFSR step:
  - ctr <= {ctr[54:0],1'b0} ^ (ctr[55] ? 56'h95 : 56'h0).
  - Polynomial is x^56+x^7+x^4+x^2+1.
  - The sequence wraps to CTR_INIT after 2^56-1 steps; no saturation.
- Command priority in IDLE: ctr_init > ctr_inc.
  - dom_ld is independent and may coincide with either.
- Commands while busy=1:
  - ctr_init, ctr_inc and dom_ld are ignored.
  - start is ignored.
- FSM states:
  - IDLE: start=1 moves to STREAM at the next edge with beat=0.
  - STREAM: tk_valid=1. A beat transfers on an edge where tk_valid&tk_ready. After the transfer of beat 3, return to IDLE.
- Snapshot rule:
  - STREAM uses the ctr/dom values registered at the edge where start is sampled.
  - If ctr_inc or dom_ld coincides with start in IDLE, the updated values are streamed.
- Beat mapping (byte 0 in bits [31:24]):
  - beat0 = {ctr[7:0], ctr[15:8], ctr[23:16], ctr[31:24]}
  - beat1 = {ctr[39:32], ctr[47:40], ctr[55:48], dom}
  - beat2 = 32'h0
  - beat3 = 32'h0
- Backpressure:
  - While tk_ready=0, tk_o and tk_valid hold stable.
  - tk_valid never drops mid-stream.
- Timing:
  - busy = (FSM==STREAM), registered.
  - tk_o is driven from registers.
  - tk_o = 0 in IDLE.
  - Latency: start -> beat0 valid in 1 cycle. Minimum stream length 4 cycles.
  - start in the cycle beat3 transfers is ignored, because busy is still 1.
- ctr_o is always the live counter register.

Optional Feature:
- Macro: TK1_CTR_WRAP_EN.
- Defined:
  - Adds output `ctr_wrap` (1 bit).
  - `ctr_wrap` is a one-cycle pulse, registered, in the cycle after an increment that returns ctr to CTR_INIT.
  - Reset value 0.
  - Testability: also adds input `ctr_force` (1 bit) and `ctr_force_val` (56 bit). In IDLE, ctr_force loads the counter, with priority above ctr_init.
- Undefined: no extra ports or logic; counter behaviour is identical.

Decomposition:
- Shared package `romulus_pkg`:
  - LFSR feedback constant 56'h95.
  - CTR_W=56, DOM_W=8, TK_BEATS=4.
  - FSM state typedef {IDLE, STREAM}.
  - Function `lfsr56_step`.
- One natural sub-module, `lfsr56_ctr`: counter register with init, inc and priority logic (plus the force/wrap logic when TK1_CTR_WRAP_EN is defined).
- The top level holds the FSM, beat counter, domain register and beat mux.

Test Plan:
- Reset, then dom_ld with dom_i=8'h04, then start, tk_ready=1 -> beats 32'h01000000, 32'h00000004, 32'h0, 32'h0 on 4 consecutive cycles; busy falls after beat 3.
- Eight ctr_inc pulses from reset -> ctr_o=56'h100. Stream -> beat0=32'h00010000, beat1=32'h00000000 with dom=0.
- 55 ctr_inc from reset -> ctr_o=56'h80000000000000. One more ctr_inc -> 56'h95. Stream beat0 = 32'h95000000.
- Stream with tk_ready toggled 0,0,1,0,1,1,1 -> each beat held stable while ready=0; exactly 4 transfers; ctr_inc and start pulses during busy are ignored (ctr_o unchanged).
- ctr_inc+start in the same IDLE cycle from reset -> streamed beat0 = 32'h02000000. ctr_init+ctr_inc together -> ctr_o=56'h1.
- rst=0 asserted during beat 1 with tk_ready=0 -> next cycle tk_valid=0, busy=0, ctr_o=56'h1. With TK1_CTR_WRAP_EN: ctr_force to 56'h02 and check ctr_o=56'h02. Separately, ctr_force_val chosen so the next step lands on 56'h1 -> ctr_inc -> ctr_wrap pulses for one cycle.

Source files
------------

// File: rtl/romulus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : romulus_pkg
// Description : Shared constants, types and helpers for the Romulus-N
//               32-bit datapath TK1 counter/stream logic.
//               - CTR_W / DOM_W / TK_BEATS / BEAT_W widths and counts
//               - LFSR_FB feedback constant for x^56+x^7+x^4+x^2+1
//               - tk1_state_e FSM state type {IDLE, STREAM}
//               - lfsr56_step() one counter step, tk1_beat() beat mux
// Revision    : 1.0 - initial release
// ============================================================================
package romulus_pkg;

  localparam int CTR_W    = 56;
  localparam int DOM_W    = 8;
  localparam int TK_BEATS = 4;
  localparam int BEAT_W   = 32;

  // Low taps of x^56 + x^7 + x^4 + x^2 + 1 (x^56 term is the shifted-out MSB).
  localparam logic [CTR_W-1:0] LFSR_FB = 56'h95;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_STREAM = 1'b1;

  typedef enum logic [0:0] {
    IDLE   = ST_IDLE,
    STREAM = ST_STREAM
  } tk1_state_e;

  // One Galois step: shift left, fold the outgoing MSB back into the taps.
  function automatic logic [CTR_W-1:0] lfsr56_step(input logic [CTR_W-1:0] ctr);
    return {ctr[CTR_W-2:0], 1'b0} ^ (ctr[CTR_W-1] ? LFSR_FB : '0);
  endfunction

  // TK1 = counter bytes 0..6 || domain || 0^64, byte 0 in the beat MSBs.
  function automatic logic [BEAT_W-1:0] tk1_beat(input logic [CTR_W-1:0] ctr,
                                                  input logic [DOM_W-1:0] dom,
                                                  input logic [1:0]       idx);
    case (idx)
      2'd0:    tk1_beat = {ctr[7:0], ctr[15:8], ctr[23:16], ctr[31:24]};
      2'd1:    tk1_beat = {ctr[39:32], ctr[47:40], ctr[55:48], dom};
      default: tk1_beat = '0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr56_ctr.sv
`default_nettype none
// ============================================================================
// Module      : lfsr56_ctr
// Description : 56-bit Romulus block-counter LFSR with init/inc priority.
//               Optional macro TK1_CTR_WRAP_EN adds a force-load path and a
//               registered wrap pulse.
// Ports       : clk, rst (sync, active-low)
//               i_en        - commands accepted only while high (idle)
//               i_init      - reload CTR_INIT (beats i_inc)
//               i_inc       - one LFSR step
//               i_force     - [TK1_CTR_WRAP_EN] load i_force_val, top priority
//               i_force_val - [TK1_CTR_WRAP_EN] forced counter value
//               o_wrap      - [TK1_CTR_WRAP_EN] 1-cycle pulse after an
//                             increment that returned to CTR_INIT
//               o_ctr       - counter register
//               o_ctr_next  - value the counter takes at the next edge
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr56_ctr
  import romulus_pkg::*;
#(
  parameter logic [CTR_W-1:0] CTR_INIT = 56'h00000000000001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_init,
  input  logic             i_inc,
`ifdef TK1_CTR_WRAP_EN
  input  logic             i_force,
  input  logic [CTR_W-1:0] i_force_val,
  output logic             o_wrap,
`endif
  output logic [CTR_W-1:0] o_ctr,
  output logic [CTR_W-1:0] o_ctr_next
);

  logic [CTR_W-1:0] r_ctr;
  logic [CTR_W-1:0] w_step;
  logic [CTR_W-1:0] w_next;

  assign w_step = lfsr56_step(r_ctr);

  always_comb begin
    w_next = r_ctr;
    if (i_en) begin
      if (i_init) begin
        w_next = CTR_INIT;
      end else if (i_inc) begin
        w_next = w_step;
      end
`ifdef TK1_CTR_WRAP_EN
      // Placed last so it overrides init/inc.
      if (i_force) begin
        w_next = i_force_val;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ctr <= CTR_INIT;
    end else begin
      r_ctr <= w_next;
    end
  end

`ifdef TK1_CTR_WRAP_EN
  logic r_wrap;
  logic w_inc_taken;

  // Only a genuine increment counts as a wrap, never an init or force load.
  assign w_inc_taken = i_en & i_inc & ~i_init & ~i_force;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= w_inc_taken && (w_step == CTR_INIT);
    end
  end

  assign o_wrap = r_wrap;
`endif

  assign o_ctr      = r_ctr;
  assign o_ctr_next = w_next;

endmodule
`default_nettype wire

// File: rtl/tk1_ctr_stream.sv
`default_nettype none
// ============================================================================
// Module      : tk1_ctr_stream
// Description : TK1 tweakey word-stream producer for the Romulus-N 32-bit
//               datapath. Holds the block counter and domain separator and
//               serialises TK1 = ctr || dom || 0^64 as four 32-bit beats over
//               a valid/ready handshake.
// Ports       : clk, rst (sync, active-low)
//               ctr_init, ctr_inc  - counter commands (idle only, init wins)
//               dom_ld, dom_i      - domain register load (idle only)
//               start              - begin a 4-beat stream (idle only)
//               busy               - stream in progress
//               tk_o, tk_valid     - beat data / valid (registered)
//               tk_ready           - downstream accept
//               ctr_o              - live counter value
//               ctr_force, ctr_force_val, ctr_wrap - only with macro
//                                    TK1_CTR_WRAP_EN defined
// Revision    : 1.0 - initial release
// ============================================================================
module tk1_ctr_stream
  import romulus_pkg::*;
#(
  parameter logic [CTR_W-1:0] CTR_INIT = 56'h00000000000001,
  parameter logic [DOM_W-1:0] DOM_RST  = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ctr_init,
  input  logic              ctr_inc,
  input  logic              dom_ld,
  input  logic [DOM_W-1:0]  dom_i,
  input  logic              start,
  output logic              busy,
  output logic [BEAT_W-1:0] tk_o,
  output logic              tk_valid,
  input  logic              tk_ready,
`ifdef TK1_CTR_WRAP_EN
  input  logic              ctr_force,
  input  logic [CTR_W-1:0]  ctr_force_val,
  output logic              ctr_wrap,
`endif
  output logic [CTR_W-1:0]  ctr_o
);

  localparam logic [1:0] c_LAST_BEAT = 2'(TK_BEATS - 1);

  tk1_state_e        r_state;
  logic [1:0]        r_beat;
  logic [BEAT_W-1:0] r_tk;
  logic [DOM_W-1:0]  r_dom;

  logic              w_idle;
  logic [1:0]        w_beat_nxt;
  logic [DOM_W-1:0]  w_dom_next;
  logic [CTR_W-1:0]  w_ctr;
  logic [CTR_W-1:0]  w_ctr_next;

  assign w_idle     = (r_state == IDLE);
  assign w_beat_nxt = r_beat + 2'd1;
  assign w_dom_next = (w_idle && dom_ld) ? dom_i : r_dom;

  lfsr56_ctr #(
    .CTR_INIT    (CTR_INIT)
  ) u_ctr (
    .clk         (clk),
    .rst         (rst),
    .i_en        (w_idle),
    .i_init      (ctr_init),
    .i_inc       (ctr_inc),
`ifdef TK1_CTR_WRAP_EN
    .i_force     (ctr_force),
    .i_force_val (ctr_force_val),
    .o_wrap      (ctr_wrap),
`endif
    .o_ctr       (w_ctr),
    .o_ctr_next  (w_ctr_next)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_beat  <= '0;
      r_tk    <= '0;
      r_dom   <= DOM_RST;
    end else begin
      r_dom <= w_dom_next;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= STREAM;
            r_beat  <= '0;
            // Snapshot uses the post-command values so a coincident
            // ctr_inc/dom_ld is reflected in the stream.
            r_tk    <= tk1_beat(w_ctr_next, w_dom_next, 2'd0);
          end
        end
        STREAM: begin
          if (tk_ready) begin
            if (r_beat == c_LAST_BEAT) begin
              r_state <= IDLE;
              r_beat  <= '0;
              r_tk    <= '0;
            end else begin
              r_beat <= w_beat_nxt;
              // ctr/dom are frozen while streaming, so the live registers
              // still hold the snapshot.
              r_tk   <= tk1_beat(w_ctr, r_dom, w_beat_nxt);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy     = (r_state == STREAM);
  assign tk_valid = (r_state == STREAM);
  assign tk_o     = r_tk;
  assign ctr_o    = w_ctr;

endmodule
`default_nettype wire

// File: tb/tb_tk1_ctr_stream.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_tk1_ctr_stream
// Description : Self-checking bench for tk1_ctr_stream. Expected beats are
//               queued by the stimulus side from a byte-level TK1 model and
//               consumed by an independent monitor on each transfer.
//               Wrap/force tests compile in when TK1_CTR_WRAP_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tk1_ctr_stream;

  localparam logic [55:0] C_INIT = 56'h1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ctr_init = 1'b0;
  logic        ctr_inc = 1'b0;
  logic        dom_ld = 1'b0;
  logic [7:0]  dom_i = 8'h0;
  logic        start = 1'b0;
  logic        tk_ready = 1'b0;
  logic        busy;
  logic [31:0] tk_o;
  logic        tk_valid;
  logic [55:0] ctr_o;
`ifdef TK1_CTR_WRAP_EN
  logic        ctr_force = 1'b0;
  logic [55:0] ctr_force_val = 56'h0;
  logic        ctr_wrap;
`endif

  always #5 clk = ~clk;

  tk1_ctr_stream dut (
    .clk           (clk),
    .rst           (rst),
    .ctr_init      (ctr_init),
    .ctr_inc       (ctr_inc),
    .dom_ld        (dom_ld),
    .dom_i         (dom_i),
    .start         (start),
    .busy          (busy),
    .tk_o          (tk_o),
    .tk_valid      (tk_valid),
    .tk_ready      (tk_ready),
`ifdef TK1_CTR_WRAP_EN
    .ctr_force     (ctr_force),
    .ctr_force_val (ctr_force_val),
    .ctr_wrap      (ctr_wrap),
`endif
    .ctr_o         (ctr_o)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [55:0] m_ctr    = C_INIT;
  logic [7:0]  m_dom    = 8'h0;
  bit          m_busy   = 1'b0;
  bit          mon_en   = 1'b0;

  // ---------------- reference model (counter as a number, TK1 as bytes)
  function automatic logic [55:0] m_step(input logic [55:0] c);
    bit          top;
    logic [55:0] d;
    top = (c >= 56'h80000000000000);
    d   = c * 56'd2;
    return top ? (d ^ 56'h95) : d;
  endfunction

  function automatic logic [31:0] m_beat(input logic [55:0] c, input logic [7:0] d, input int k);
    logic [7:0] b[16];
    for (int i = 0; i < 16; i++) b[i] = 8'h0;
    for (int i = 0; i < 7; i++)  b[i] = c[8*i +: 8];
    b[7] = d;
    return {b[4*k], b[4*k+1], b[4*k+2], b[4*k+3]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard
  initial begin
    bit          hold;
    logic [31:0] held;
    logic [31:0] e;
    hold = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (mon_en && rst) begin
        chk("valid_vs_model", 64'(tk_valid), 64'(m_busy));
        chk("busy_vs_model", 64'(busy), 64'(m_busy));
        if (!m_busy) chk("idle_tk_zero", 64'(tk_o), 64'h0);
        if (m_busy && hold) chk("hold_stable", 64'(tk_o), 64'(held));
        if (tk_valid && tk_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_beat: got %0h expected no beat", tk_o);
          end else begin
            e = exp_q.pop_front();
            chk("beat", 64'(tk_o), 64'(e));
          end
        end
        hold = tk_valid && !tk_ready;
        held = tk_o;
      end else begin
        hold = 1'b0;
      end
    end
  end

  // ---------------- stimulus helpers (all start and end at posedge+1)
  task automatic clr_cmds();
    ctr_init = 1'b0;
    ctr_inc  = 1'b0;
    dom_ld   = 1'b0;
    start    = 1'b0;
`ifdef TK1_CTR_WRAP_EN
    ctr_force = 1'b0;
`endif
  endtask

  task automatic do_reset();
    clr_cmds();
    tk_ready = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    m_busy = 1'b0;
    m_ctr  = C_INIT;
    m_dom  = 8'h0;
    mon_en = 1'b1;
    chk("rst_ctr", 64'(ctr_o), 64'(C_INIT));
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_valid", 64'(tk_valid), 64'h0);
    chk("rst_tk", 64'(tk_o), 64'h0);
  endtask

  task automatic idle_cmd(input bit init, input bit inc, input bit dl, input logic [7:0] d, input bit st);
    bit exp_wrap;
    exp_wrap = inc && !init && (m_step(m_ctr) == C_INIT);
    ctr_init = init;
    ctr_inc  = inc;
    dom_ld   = dl;
    dom_i    = d;
    start    = st;
    if (init)     m_ctr = C_INIT;
    else if (inc) m_ctr = m_step(m_ctr);
    if (dl) m_dom = d;
    if (st) for (int k = 0; k < 4; k++) exp_q.push_back(m_beat(m_ctr, m_dom, k));
    @(posedge clk); #1;
    clr_cmds();
    if (st) m_busy = 1'b1;
    chk("cmd_ctr", 64'(ctr_o), 64'(m_ctr));
`ifdef TK1_CTR_WRAP_EN
    chk("wrap_pulse", 64'(ctr_wrap), 64'(exp_wrap));
`endif
  endtask

  // mode 0: ready always, 1: random ready, 2: pattern 0,0,1,0,1,1,1
  task automatic run_stream(input int mode, input bit junk, input int exp_cycles);
    int cyc;
    int pat[7];
    pat = '{0, 0, 1, 0, 1, 1, 1};
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 100) begin
      case (mode)
        0:       tk_ready = 1'b1;
        1:       tk_ready = 1'($urandom_range(0, 1));
        default: tk_ready = (cyc < 7) ? (pat[cyc] != 0) : 1'b1;
      endcase
      if (junk) begin
        ctr_inc  = 1'($urandom_range(0, 1));
        ctr_init = 1'($urandom_range(0, 1));
        start    = 1'($urandom_range(0, 1));
        dom_ld   = 1'($urandom_range(0, 1));
        dom_i    = 8'($urandom);
      end
      @(posedge clk); #1;
      cyc++;
    end
    tk_ready = 1'b0;
    clr_cmds();
    chk("stream_complete", 64'(exp_q.size()), 64'h0);
    exp_q.delete();
    m_busy = 1'b0;
    chk("end_busy", 64'(busy), 64'h0);
    chk("end_ctr", 64'(ctr_o), 64'(m_ctr));
    if (exp_cycles > 0) chk("stream_len", 64'(cyc), 64'(exp_cycles));
  endtask

  // ---------------- main sequence
  initial begin
    @(posedge clk); #1;
    do_reset();

    // Domain 04, back-to-back stream of four beats.
    idle_cmd(0, 0, 1, 8'h04, 0);
    idle_cmd(0, 0, 0, 8'h00, 1);
    run_stream(0, 0, 4);

    // Eight increments -> 0x100.
    do_reset();
    for (int i = 0; i < 8; i++) idle_cmd(0, 1, 0, 8'h00, 0);
    chk("ctr_8inc", 64'(ctr_o), 64'h100);
    idle_cmd(0, 0, 0, 8'h00, 1);
    run_stream(0, 0, 4);

    // Feedback boundary: MSB set, then fold into the taps.
    do_reset();
    for (int i = 0; i < 55; i++) idle_cmd(0, 1, 0, 8'h00, 0);
    chk("ctr_55inc", 64'(ctr_o), 64'h80000000000000);
    idle_cmd(0, 1, 0, 8'h00, 0);
    chk("ctr_fold", 64'(ctr_o), 64'h95);
    idle_cmd(0, 0, 0, 8'h00, 1);
    run_stream(0, 0, 4);

    // Backpressure pattern with ignored commands while busy.
    idle_cmd(0, 0, 1, 8'h5A, 1);
    run_stream(2, 1, 7);

    // Coincident inc + start streams the updated counter; init beats inc.
    do_reset();
    idle_cmd(0, 1, 0, 8'h00, 1);
    run_stream(0, 0, 4);
    idle_cmd(1, 1, 0, 8'h00, 0);
    chk("init_over_inc", 64'(ctr_o), 64'h1);

    // Randomized command mix and random backpressure.
    for (int it = 0; it < 20; it++) begin
      int n;
      n = int'($urandom_range(0, 3));
      for (int j = 0; j < n; j++)
        idle_cmd(($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 8'($urandom), 0);
      idle_cmd(($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 8'($urandom), 1);
      run_stream(1, 1, 0);
    end

    // Reset during beat 1 with the sink stalled.
    idle_cmd(0, 1, 0, 8'h00, 0);
    idle_cmd(0, 1, 1, 8'hA5, 1);
    tk_ready = 1'b1;
    @(posedge clk); #1;
    tk_ready = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    m_busy = 1'b0;
    m_ctr  = C_INIT;
    m_dom  = 8'h0;
    chk("abort_valid", 64'(tk_valid), 64'h0);
    chk("abort_busy", 64'(busy), 64'h0);
    chk("abort_ctr", 64'(ctr_o), 64'h1);
    for (int i = 0; i < 3; i++) begin
      tk_ready = 1'b1;
      @(posedge clk); #1;
    end
    tk_ready = 1'b0;
    idle_cmd(0, 0, 0, 8'h00, 1);
    run_stream(0, 0, 4);

`ifdef TK1_CTR_WRAP_EN
    // Force beats init; then force to the predecessor of CTR_INIT and step.
    ctr_force     = 1'b1;
    ctr_force_val = 56'h02;
    ctr_init      = 1'b1;
    @(posedge clk); #1;
    clr_cmds();
    m_ctr = 56'h02;
    chk("force_ctr", 64'(ctr_o), 64'h02);
    chk("force_nowrap", 64'(ctr_wrap), 64'h0);
    ctr_force     = 1'b1;
    ctr_force_val = 56'h8000000000004A;
    @(posedge clk); #1;
    clr_cmds();
    m_ctr = 56'h8000000000004A;
    chk("force_pre", 64'(ctr_o), 64'(m_ctr));
    idle_cmd(0, 1, 0, 8'h00, 0);
    chk("wrap_ctr", 64'(ctr_o), 64'h1);
    @(posedge clk); #1;
    chk("wrap_one_cycle", 64'(ctr_wrap), 64'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
